// File: rtl/fetch_issue_mt_pkg.sv
// Shared definitions for the multi-hart fetch issue stage: default step,
// width helper and redirect-cause encodings kept for the trap extension.
package fetch_issue_mt_pkg;

    localparam int DEFAULT_PC_STEP = 4;

    // Redirect causes are not yet consumed by the issue stage; the trap
    // extension will carry one of these alongside redirect_valid.
    typedef enum logic [1:0] {
        CAUSE_JUMP     = 2'd0,
        CAUSE_BRANCH   = 2'd1,
        CAUSE_TRAP     = 2'd2,
        CAUSE_RESERVED = 2'd3
    } redirect_cause_e;

    // log2 rounded up, never below 1 so a single-hart build still has a
    // one-bit hart id.
    function automatic int clog2_min1(input int n);
        int bits;
        bits = 0;
        while ((1 << bits) < n) begin
            bits = bits + 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/fetch_issue_mt_if.sv
// Fetch request channel between the issue stage (master) and the icache (slave).
interface fetch_issue_mt_if #(
    parameter int ADDRESS_BITS = 20,
    parameter int HART_BITS    = 2
);
    // Handshake: the master raises i_mem_read with a valid address; the
    // transfer happens in any cycle where i_mem_read and i_mem_ready are both
    // high. The master may change or drop the request in a cycle without a
    // transfer, so the slave samples the address only on a transfer.
    logic                    i_mem_read;
    logic                    i_mem_ready;
    logic [ADDRESS_BITS-1:0] i_mem_read_address;
    logic [ADDRESS_BITS-1:0] issue_PC;
    logic [HART_BITS-1:0]    issue_hart;

    modport master (
        output i_mem_read,
        output i_mem_read_address,
        output issue_PC,
        output issue_hart,
        input  i_mem_ready
    );

    modport slave (
        input  i_mem_read,
        input  i_mem_read_address,
        input  issue_PC,
        input  issue_hart,
        output i_mem_ready
    );

endinterface

// File: rtl/fetch_issue_mt_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request after the last
// grant, wrapping modulo N. Shared with the memory arbiters.
module rr_arbiter
    import fetch_issue_mt_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] request,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] grant_onehot,
    output logic [W-1:0] grant_index,
    output logic         any_grant
);

    int           idx;
    logic [W-1:0] idx_w;

    // With no request the encoded grant stays on last_grant so downstream
    // muxes see a stable selection.
    always_comb begin
        grant_onehot = '0;
        grant_index  = last_grant;
        any_grant    = 1'b0;
        idx          = 0;
        idx_w        = '0;
        for (int i = 1; i <= N; i++) begin
            idx   = (int'(last_grant) + i) % N;
            idx_w = W'(idx);
            if (!any_grant && request[idx_w]) begin
                any_grant           = 1'b1;
                grant_index         = idx_w;
                grant_onehot[idx_w] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_issue_mt.sv
// Barrel-threaded PC generator: one PC per hart, round-robin pick of an
// eligible hart each cycle, issued to the icache over a valid/ready channel.
module fetch_issue_mt
    import fetch_issue_mt_pkg::*;
#(
    parameter int          CORE         = 0,
    parameter int unsigned RESET_PC     = 0,
    parameter int          ADDRESS_BITS = 20,
    parameter int          NUM_HARTS    = 4,
    parameter int          HART_BITS    = 2,
    parameter int          PC_STEP      = DEFAULT_PC_STEP
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_HARTS-1:0]    hart_enable,
    input  logic [NUM_HARTS-1:0]    hart_stall,
    input  logic                    redirect_valid,
    input  logic [HART_BITS-1:0]    redirect_hart,
    input  logic [ADDRESS_BITS-1:0] target_PC,
    fetch_issue_mt_if.master        imem,
    input  logic                    scan,
    output logic [HART_BITS-1:0]    debug_rr_ptr,
    output logic [7:0]              debug_core
);

    localparam logic [ADDRESS_BITS-1:0] RESET_PC_W = ADDRESS_BITS'(RESET_PC);
    localparam logic [ADDRESS_BITS-1:0] STEP_W     = ADDRESS_BITS'(PC_STEP);
    localparam logic [HART_BITS-1:0]    LAST_HART  = HART_BITS'(NUM_HARTS - 1);

    logic [ADDRESS_BITS-1:0] pc_reg [NUM_HARTS];
    logic [HART_BITS-1:0]    rr_ptr;
    logic [NUM_HARTS-1:0]    eligible;
    logic [NUM_HARTS-1:0]    grant_onehot;
    logic [HART_BITS-1:0]    sel;
    logic                    any_eligible;
    logic                    fire;

    // A hart being redirected is masked so its stale PC never goes out in
    // the redirect cycle; this also keeps redirect and fire on different harts.
    always_comb begin
        eligible = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            eligible[h] = hart_enable[h] & ~hart_stall[h]
                        & ~(redirect_valid && (redirect_hart == HART_BITS'(h)));
        end
    end

    rr_arbiter #(
        .N (NUM_HARTS),
        .W (HART_BITS)
    ) u_rr_arbiter (
        .request      (eligible),
        .last_grant   (rr_ptr),
        .grant_onehot (grant_onehot),
        .grant_index  (sel),
        .any_grant    (any_eligible)
    );

    assign fire = any_eligible & imem.i_mem_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                pc_reg[h] <= RESET_PC_W;
            end
            rr_ptr <= LAST_HART;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (redirect_valid && (redirect_hart == HART_BITS'(h))) begin
                    pc_reg[h] <= target_PC;
                end else if (fire && grant_onehot[h]) begin
                    pc_reg[h] <= pc_reg[h] + STEP_W;
                end
            end
            if (fire) begin
                rr_ptr <= sel;
            end
        end
    end

    // sel falls back to rr_ptr when nothing is eligible, keeping the idle
    // request address stable.
    assign imem.i_mem_read         = any_eligible;
    assign imem.issue_hart         = sel;
    assign imem.issue_PC           = pc_reg[sel];
    assign imem.i_mem_read_address = pc_reg[sel];

    assign debug_rr_ptr = rr_ptr;
    assign debug_core   = scan ? 8'(CORE) : 8'd0;

endmodule
